// File: rtl/instr_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_queue
// Purpose  : In-order fetch-to-decode instruction FIFO with one-cycle flush.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     if_valid,
    input  logic [31:0]              if_instr,
    input  logic [31:0]              if_pc,
    output logic                     if_ready,
    input  logic                     flush,
    input  logic                     id_ready,
    output logic                     id_valid,
    output logic [31:0]              id_instr,
    output logic [31:0]              id_pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int                c_AW   = $clog2(DEPTH);
    localparam logic [c_AW:0]     c_FULL = (c_AW+1)'(DEPTH);
    localparam logic [c_AW-1:0]   c_ONE  = c_AW'(1);

    logic [63:0]     r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic            w_push;
    logic            w_pop;
    logic [63:0]     w_head;

    // Handshake outputs come from registered occupancy only.
    assign if_ready = (r_count != c_FULL);
    assign id_valid = (r_count != '0);
    assign w_push   = if_valid & if_ready;
    assign w_pop    = id_valid & id_ready;
    assign w_head   = r_mem[r_rd_ptr];
    assign id_instr = id_valid ? w_head[63:32] : 32'h0000_0000;
    assign id_pc    = id_valid ? w_head[31:0]  : 32'h0000_0000;
    assign count    = r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_AW+1)'(1);
                2'b01:   r_count <= r_count - (c_AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; a flush only suppresses the write.
    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_mem[r_wr_ptr] <= {if_instr, if_pc};
        end
    end

endmodule
`default_nettype wire
